rs232_line_assembler: RTL and testbench
=======================================

RS232_LINE_ASSEMBLER -- requirements
Module: rs232_line_assembler

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, line buffer depth in bytes (power of two, 4..256).
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0A, the line terminator byte.
REQ-003 SHALL have parameter DROP_CR, default 1'b1; when 1, byte 8'h0D is discarded.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have Avalon-MM master ports to the UART register slave: address output 1 (0=data, 1=control); chipselect output 1; read output 1; write output 1; byteenable output 4; writedata output 32; readdata input 32.
REQ-007 SHALL have port line_valid, output, 1, meaning a completed line is held in the buffer.
REQ-008 SHALL have port line_length, output, $clog2(MAX_LEN)+1, the stored byte count (1..MAX_LEN).
REQ-009 SHALL have port line_overflow, output, 1, meaning the held line was truncated.
REQ-010 SHALL have port line_rd_addr, input, $clog2(MAX_LEN), the buffer read index.
REQ-011 SHALL have port line_rd_data, output, 8, the buffer byte at line_rd_addr, registered with 1-cycle latency.
REQ-012 SHALL have port line_ack, input, 1, a one-cycle pulse that releases the held line.

Function
REQ-013 SHALL implement states POLL_REQ, POLL_WAIT and LINE_READY, plus ECHO_REQ, ECHO_WAIT and ECHO_WR when echo is compiled in.
REQ-014 In POLL_REQ, SHALL assert chipselect=1, read=1, address=0 and byteenable=4'b0001 for exactly one cycle, then enter POLL_WAIT.
REQ-015 In POLL_WAIT, SHALL sample readdata (valid one cycle after the request) as follows: available=[23:16], parity_err=[9], byte=[7:0].
REQ-016 If available==0, SHALL discard the sample and return to POLL_REQ; the peak rate is 1 byte per 2 cycles.
REQ-017 If parity_err==1, SHALL drop the byte and set the sticky error flag.
REQ-018 If the byte is 8'h0D and DROP_CR==1, SHALL drop the byte.
REQ-019 If the byte equals TERM_CHAR and the count is >0, SHALL latch line_length, raise line_valid and enter LINE_READY.
REQ-020 If the byte equals TERM_CHAR and the count is 0, SHALL suppress the empty line and continue polling.
REQ-021 Any other byte SHALL be written to buffer[count] with count+1 when count<MAX_LEN; when count==MAX_LEN it SHALL be dropped and line_overflow set.
REQ-022 In LINE_READY, SHALL issue no bus cycles; bytes are held in the UART FIFO as backpressure.
REQ-023 On line_ack in LINE_READY, SHALL clear line_valid, line_overflow and count, and enter POLL_REQ on the next cycle.
REQ-024 SHALL ignore line_ack outside LINE_READY.
REQ-025 SHALL hold write=0 at all times except in ECHO_WR.
REQ-026 SHALL never assert read and write in the same cycle.

Reset
REQ-027 On reset, SHALL clear to 0: state=POLL_REQ, chipselect, read, write, byteenable, writedata, line_valid, line_length, line_overflow, line_rd_data, count and the error flag.
REQ-028 Reset asserted mid-line SHALL discard the partial line; the first bus cycle SHALL be a POLL_REQ in the first cycle after release.

Configuration
REQ-029 Macro RS232_LINE_ECHO_EN: when defined, every accepted byte (including TERM_CHAR, excluding dropped bytes) SHALL be echoed by the ECHO sequence below.
REQ-030 ECHO_REQ SHALL read address=1; ECHO_WAIT SHALL check write_space=readdata[23:16], returning to ECHO_REQ if 0 and entering ECHO_WR otherwise.
REQ-031 ECHO_WR SHALL assert write=1, address=0, byteenable=4'b0001 and writedata={24'h0,byte} for one cycle, then go to LINE_READY on TERM_CHAR or POLL_REQ otherwise.
REQ-032 When RS232_LINE_ECHO_EN is undefined, the ECHO states SHALL not exist, write SHALL be tied to 0 and writedata SHALL be tied to 0.

Structure
REQ-033 Package rs232_line_pkg SHALL hold the state enum, the register address constants (DATA=0, CTRL=1) and the field positions (AVAIL_LSB=16, WSPACE_LSB=16, PERR_BIT=9).
REQ-034 Sub-module rs232_line_buffer SHALL hold the MAX_LEN x 8 single-write, registered-read storage.

Verification
REQ-035 Supply "AB\n" with available>0 -> line_valid=1, line_length=2, reading addresses 0 and 1 returns 8'h41 and 8'h42.
REQ-036 Supply "\r\n" then "X\n" -> the first line is suppressed; line_length=1 and data=8'h58.
REQ-037 Supply 70 bytes then 8'h0A with MAX_LEN=64 -> line_length=64 and line_overflow=1.
REQ-038 While line_valid is held for 20 cycles -> read=0 and chipselect=0 throughout; after line_ack, a POLL_REQ occurs within 1 cycle.
REQ-039 Assert reset after 3 bytes of "ABCD" -> all outputs read 0; a following "Z\n" gives length=1.
REQ-040 With RS232_LINE_ECHO_EN and write_space=0 for 5 polls then 8 -> a single write of {24'h0,8'h41} occurs after the sixth control read.

Source files
------------

// File: rtl/rs232_line_pkg.sv
// rs232_line_pkg: shared types and constants for the RS-232 line assembler.
//   state_e     - FSM states (echo states only when RS232_LINE_ECHO_EN is defined)
//   ADDR_*      - UART register-slave addresses
//   *_LSB/*_BIT - field positions inside the UART readdata word
// Optional feature macro: RS232_LINE_ECHO_EN
package rs232_line_pkg;

`ifdef RS232_LINE_ECHO_EN
  typedef enum logic [2:0] {
    POLL_REQ, POLL_WAIT, LINE_READY, ECHO_REQ, ECHO_WAIT, ECHO_WR
  } state_e;
`else
  typedef enum logic [1:0] {
    POLL_REQ, POLL_WAIT, LINE_READY
  } state_e;
`endif

  localparam logic       ADDR_DATA  = 1'b0;
  localparam logic       ADDR_CTRL  = 1'b1;
  localparam int         AVAIL_LSB  = 16;
  localparam int         WSPACE_LSB = 16;
  localparam int         PERR_BIT   = 9;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Extract an 8-bit field starting at lsb.
  function automatic logic [7:0] field8(input logic [31:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/rs232_line_buffer.sv
// rs232_line_buffer: DEPTH x 8 line storage, one write port, registered read.
//   clk, reset     - clock, async active-high reset (clears the read register only)
//   we_i/waddr_i/wdata_i - write port
//   raddr_i        - read index
//   rdata_o        - byte at raddr_i, one cycle later
module rs232_line_buffer #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rs232_line_assembler.sv
// rs232_line_assembler: polls a UART register slave over Avalon-MM, assembles
// received bytes into a line buffer and holds the line until acknowledged.
//   clk, reset                 - clock, async active-high reset
//   address..writedata,readdata - Avalon-MM master to the UART (0=data, 1=control)
//   line_valid/length/overflow - held-line status
//   line_rd_addr/line_rd_data  - buffer read port (1-cycle latency)
//   line_ack                   - releases the held line
// Optional feature macro: RS232_LINE_ECHO_EN (echo accepted bytes back to the UART)
module rs232_line_assembler
  import rs232_line_pkg::*;
#(
  parameter  int         MAX_LEN   = 64,
  parameter  logic [7:0] TERM_CHAR = 8'h0A,
  parameter  bit         DROP_CR   = 1'b1,
  localparam int         AW        = $clog2(MAX_LEN),
  localparam int         CW        = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          address,
  output logic          chipselect,
  output logic          read,
  output logic          write,
  output logic [3:0]    byteenable,
  output logic [31:0]   writedata,
  input  logic [31:0]   readdata,
  output logic          line_valid,
  output logic [CW-1:0] line_length,
  output logic          line_overflow,
  input  logic [AW-1:0] line_rd_addr,
  output logic [7:0]    line_rd_data,
  input  logic          line_ack
);

  localparam logic [CW-1:0] FULL = CW'(MAX_LEN);

  state_e        state_q;
  logic          cs_q, rd_q, addr_q, valid_q, ovf_q, err_q;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt_q, len_q;

  // Decode of the data-register sample seen in POLL_WAIT
  logic       rx_avail, rx_perr, rx_cr, rx_term, rx_keep, buf_we;
  logic [7:0] rx_byte;

  assign rx_avail = field8(readdata, AVAIL_LSB) != 8'h00;
  assign rx_perr  = readdata[PERR_BIT];
  assign rx_byte  = readdata[7:0];
  assign rx_cr    = DROP_CR && (rx_byte == 8'h0D);
  assign rx_term  = rx_byte == TERM_CHAR;
  assign rx_keep  = rx_avail && !rx_perr && !rx_cr;
  assign buf_we   = (state_q == POLL_WAIT) && rx_keep && !rx_term && (cnt_q < FULL);

`ifdef RS232_LINE_ECHO_EN
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [7:0]  echo_q;
`endif

  // Request strobes default low every cycle; a transition that enters a
  // request state raises them for exactly that state's single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= POLL_REQ;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= ADDR_DATA;
      be_q    <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef RS232_LINE_ECHO_EN
      wr_q    <= 1'b0;
      wdata_q <= '0;
      echo_q  <= '0;
`endif
    end else begin
      cs_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= ADDR_DATA;
      be_q   <= '0;
`ifdef RS232_LINE_ECHO_EN
      wr_q    <= 1'b0;
      wdata_q <= '0;
`endif
      case (state_q)
        POLL_REQ: begin
          // Strobes are low only on the first cycle after reset: issue now.
          if (cs_q) begin
            state_q <= POLL_WAIT;
          end else begin
            cs_q <= 1'b1; rd_q <= 1'b1; be_q <= BE_BYTE0;
          end
        end
        POLL_WAIT: begin
          state_q <= POLL_REQ;
          cs_q <= 1'b1; rd_q <= 1'b1; be_q <= BE_BYTE0;
          if (rx_avail && rx_perr) err_q <= 1'b1;
          if (rx_keep) begin
            if (rx_term) begin
              if (cnt_q != '0) begin
                len_q <= cnt_q;
`ifdef RS232_LINE_ECHO_EN
                echo_q  <= rx_byte;
                state_q <= ECHO_REQ;
                addr_q  <= ADDR_CTRL; be_q <= BE_WORD;
`else
                valid_q <= 1'b1;
                state_q <= LINE_READY;
                cs_q <= 1'b0; rd_q <= 1'b0; be_q <= '0;
`endif
              end
            end else if (cnt_q < FULL) begin
              cnt_q <= cnt_q + 1'b1;
`ifdef RS232_LINE_ECHO_EN
              echo_q  <= rx_byte;
              state_q <= ECHO_REQ;
              addr_q  <= ADDR_CTRL; be_q <= BE_WORD;
`endif
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        LINE_READY: begin
          // No bus traffic: unread bytes stay in the UART FIFO.
          if (line_ack) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= POLL_REQ;
            cs_q <= 1'b1; rd_q <= 1'b1; be_q <= BE_BYTE0;
          end
        end
`ifdef RS232_LINE_ECHO_EN
        ECHO_REQ: state_q <= ECHO_WAIT;
        ECHO_WAIT: begin
          cs_q <= 1'b1;
          if (field8(readdata, WSPACE_LSB) == 8'h00) begin
            state_q <= ECHO_REQ;
            rd_q <= 1'b1; addr_q <= ADDR_CTRL; be_q <= BE_WORD;
          end else begin
            state_q <= ECHO_WR;
            wr_q <= 1'b1; be_q <= BE_BYTE0; wdata_q <= {24'h0, echo_q};
          end
        end
        ECHO_WR: begin
          if (echo_q == TERM_CHAR && len_q != '0 && cnt_q == len_q) begin
            valid_q <= 1'b1;
            state_q <= LINE_READY;
          end else begin
            state_q <= POLL_REQ;
            cs_q <= 1'b1; rd_q <= 1'b1; be_q <= BE_BYTE0;
          end
        end
`endif
        default: state_q <= POLL_REQ;
      endcase
    end
  end

  rs232_line_buffer #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (buf_we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (rx_byte),
    .raddr_i (line_rd_addr),
    .rdata_o (line_rd_data)
  );

  assign address       = addr_q;
  assign chipselect    = cs_q;
  assign read          = rd_q;
  assign byteenable    = be_q;
  assign line_valid    = valid_q;
  assign line_length   = len_q;
  assign line_overflow = ovf_q;

`ifdef RS232_LINE_ECHO_EN
  assign write     = wr_q;
  assign writedata = wdata_q;
`else
  assign write     = 1'b0;
  assign writedata = '0;
`endif

  // Fields of readdata the design does not look at, plus the internal error flag
  logic unused_bits;
  assign unused_bits = ^{readdata[31:24], readdata[15:10], readdata[8], err_q};

endmodule

// File: tb/tb_rs232_line_assembler.sv
module tb_rs232_line_assembler;

  localparam int MAX_LEN = 64;
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;

  logic          clk, reset;
  logic          address, chipselect, read, write;
  logic [3:0]    byteenable;
  logic [31:0]   writedata, readdata;
  logic          line_valid, line_overflow, line_ack;
  logic [CW-1:0] line_length;
  logic [AW-1:0] line_rd_addr;
  logic [7:0]    line_rd_data;

  int checks = 0;
  int errors = 0;

  rs232_line_assembler #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .line_valid(line_valid), .line_length(line_length),
    .line_overflow(line_overflow), .line_rd_addr(line_rd_addr),
    .line_rd_data(line_rd_data), .line_ack(line_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART slave model: registered readdata, RX FIFO of {perr, byte}
  logic [8:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         tx_at_ctrl[$];
  int         ctrl_reads = 0;
  int         wspace_zero_until = 0;

  always @(posedge clk) begin
    logic [8:0] e;
    if (chipselect && read) begin
      if (address == 1'b0) begin
        if (rx_q.size() > 0) begin
          e = rx_q.pop_front();
          readdata <= {8'h0, 8'(rx_q.size() + 1), 6'h0, e[8], 1'b0, e[7:0]};
        end else begin
          readdata <= 32'h0;
        end
      end else begin
        readdata   <= {8'h0, (ctrl_reads < wspace_zero_until) ? 8'h00 : 8'h08, 16'h0};
        ctrl_reads <= ctrl_reads + 1;
      end
    end
    if (chipselect && write) begin
      tx_q.push_back(writedata[7:0]);
      tx_at_ctrl.push_back(ctrl_reads);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      chk("rd_wr_excl", {31'b0, read & write}, 32'h0);
`ifndef RS232_LINE_ECHO_EN
      chk("write_tied0", {31'b0, write}, 32'h0);
`endif
    end
  end

  // Reference model of line assembly; fills the expected-result queues
  int         m_cnt = 0;
  bit         m_ovf = 0;
  logic [7:0] m_buf[$];
  int         exp_len_q[$];
  bit         exp_ovf_q[$];
  logic [7:0] exp_byte_q[$];

  task automatic model_clear();
    m_cnt = 0; m_ovf = 0; m_buf.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit perr = 1'b0);
    rx_q.push_back({perr, b});
    if (perr || b == 8'h0D) return;
    if (b == 8'h0A) begin
      if (m_cnt > 0) begin
        exp_len_q.push_back(m_cnt);
        exp_ovf_q.push_back(m_ovf);
        foreach (m_buf[i]) exp_byte_q.push_back(m_buf[i]);
      end
      model_clear();
    end else if (m_cnt < MAX_LEN) begin
      m_buf.push_back(b); m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_line(input string tag, input int hold = 0);
    int t = 0;
    int len;
    bit ovf;
    while (!line_valid && t < 3000) begin tick(); t++; end
    chk({tag, "_valid"}, {31'b0, line_valid}, 32'h1);
    if (!line_valid) return;
    if (exp_len_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: observed line_valid=1 expected no pending line", tag);
      return;
    end
    len = exp_len_q.pop_front();
    ovf = exp_ovf_q.pop_front();
    chk({tag, "_len"}, 32'(line_length), 32'(len));
    chk({tag, "_ovf"}, {31'b0, line_overflow}, {31'b0, ovf});
    for (int i = 0; i < len; i++) begin
      line_rd_addr = AW'(i);
      tick();
      chk($sformatf("%s_data%0d", tag, i), {24'h0, line_rd_data}, {24'h0, exp_byte_q.pop_front()});
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_rd"}, {31'b0, read}, 32'h0);
      chk({tag, "_hold_cs"}, {31'b0, chipselect}, 32'h0);
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    chk({tag, "_ack_valid"}, {31'b0, line_valid}, 32'h0);
    chk({tag, "_ack_poll"}, {30'b0, read, address}, 32'h2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"}, {31'b0, chipselect}, 32'h0);
    chk({tag, "_rd"}, {31'b0, read}, 32'h0);
    chk({tag, "_wr"}, {31'b0, write}, 32'h0);
    chk({tag, "_be"}, {28'b0, byteenable}, 32'h0);
    chk({tag, "_wdata"}, writedata, 32'h0);
    chk({tag, "_valid"}, {31'b0, line_valid}, 32'h0);
    chk({tag, "_len"}, 32'(line_length), 32'h0);
    chk({tag, "_ovf"}, {31'b0, line_overflow}, 32'h0);
    chk({tag, "_rdata"}, {24'h0, line_rd_data}, 32'h0);
  endtask

  initial begin
    int t;
    reset = 1'b1; line_ack = 1'b0; line_rd_addr = '0; readdata = 32'h0;
    tick(2);
    check_reset_outputs("rst0");
    reset = 1'b0;
    tick();
    chk("first_poll", {29'b0, read, chipselect, address}, 32'h6);

    // "AB\n", then hold the line for 20 cycles
    send(8'h41); send(8'h42); send(8'h0A);
    check_line("ab", 20);

    // "\r\n" suppressed, then "X\n"
    send(8'h0D); send(8'h0A); send(8'h58); send(8'h0A);
    check_line("x");

    // Parity-errored byte dropped
    send(8'h50, 1'b1); send(8'h51); send(8'h0A);
    check_line("perr");

    // 70 bytes then terminator: truncated to MAX_LEN
    for (int i = 0; i < 70; i++) send(8'(8'h20 + i));
    send(8'h0A);
    check_line("ovf");

    // Reset mid-line after three of "ABCD" have been fetched
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    t = 0;
    while (rx_q.size() > 1 && t < 200) begin tick(); t++; end
    chk("mid_fetch", 32'(rx_q.size()), 32'h1);
    reset = 1'b1;
    tick();
    check_reset_outputs("rst1");
    rx_q.delete();
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    chk("rst1_poll", {29'b0, read, chipselect, address}, 32'h6);
    send(8'h5A); send(8'h0A);
    check_line("z");

`ifdef RS232_LINE_ECHO_EN
    begin
      int tx_base, ctrl_base;
      tx_base = tx_q.size();
      ctrl_base = ctrl_reads;
      wspace_zero_until = ctrl_reads + 5;
      send(8'h41); send(8'h0A);
      check_line("echo");
      chk("echo_cnt", 32'(tx_q.size() - tx_base), 32'h2);
      if (tx_q.size() >= tx_base + 2) begin
        chk("echo_b0", {24'h0, tx_q[tx_base]}, 32'h41);
        chk("echo_after", 32'(tx_at_ctrl[tx_base] - ctrl_base), 32'h6);
        chk("echo_b1", {24'h0, tx_q[tx_base + 1]}, 32'h0A);
      end
    end
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
